// File: rtl/grid_manager_pkg.sv
// Shared tetris constants: playfield geometry, grid FSM encoding, renderer cell size.
package grid_manager_pkg;

    localparam int unsigned ROWS    = 30;
    localparam int unsigned COLS    = 10;
    localparam int unsigned CELLS   = ROWS * COLS;
    localparam int unsigned CELL_PX = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StScan  = 2'd1,
        StShift = 2'd2,
        StDone  = 2'd3
    } state_t;

endpackage

// File: rtl/grid_row_select.sv
// Picks the row addressed by ptr out of the flat playfield and flags it when every cell is set.
module grid_row_select #(
    parameter int unsigned ROWS  = grid_manager_pkg::ROWS,
    parameter int unsigned COLS  = grid_manager_pkg::COLS,
    parameter int unsigned PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic [ROWS*COLS-1:0] grid,
    input  logic [PTR_W-1:0]     ptr,
    output logic                 full
);

    logic [COLS-1:0] row;

    // Row multiplexer; pointer values past the last row read as an empty row.
    always_comb begin
        row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(ptr) == r) begin
                row = grid[r*COLS +: COLS];
            end
        end
    end

    assign full = &row;

endmodule

// File: rtl/grid_manager.sv
// Playfield owner: merges settled pieces, then sweeps bottom-up removing full rows.
module grid_manager #(
    parameter int unsigned ROWS = grid_manager_pkg::ROWS,
    parameter int unsigned COLS = grid_manager_pkg::COLS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lock_valid,
    input  logic [ROWS*COLS-1:0] lock_mask,
    output logic                 lock_ready,
    input  logic                 clear_all,
    output logic [ROWS*COLS-1:0] grid,
    output logic                 busy,
    output logic                 lines_valid,
    output logic [2:0]           lines_cleared,
    output logic                 game_over
);

    import grid_manager_pkg::*;

    localparam int unsigned      PTR_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(ROWS - 1);

    state_t                 state_q;
    logic [PTR_W-1:0]       ptr_q;
    logic                   row_full;
    logic [ROWS*COLS-1:0]   shifted;

    grid_row_select #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .PTR_W (PTR_W)
    ) u_row_select (
        .grid (grid),
        .ptr  (ptr_q),
        .full (row_full)
    );

    // Shift network: drop everything above the pointer by one row, feed zeros in at the top.
    always_comb begin
        shifted           = grid;
        shifted[0 +: COLS] = '0;
        for (int r = 1; r < ROWS; r++) begin
            if (r <= int'(ptr_q)) begin
                shifted[r*COLS +: COLS] = grid[(r-1)*COLS +: COLS];
            end
        end
    end

    assign lock_ready = (state_q == StIdle);
    assign busy       = (state_q != StIdle);

    // Lock/scan/shift sequencer; clear_all overrides everything and aborts a sweep silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            grid          <= '0;
            ptr_q         <= PTR_TOP;
            lines_cleared <= 3'd0;
            lines_valid   <= 1'b0;
            game_over     <= 1'b0;
        end else if (clear_all) begin
            state_q       <= StIdle;
            grid          <= '0;
            ptr_q         <= PTR_TOP;
            lines_cleared <= 3'd0;
            lines_valid   <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            lines_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (lock_valid) begin
                        grid          <= grid | lock_mask;
                        // Collision still merges; the flag is sticky until a new game.
                        if (|(grid & lock_mask)) begin
                            game_over <= 1'b1;
                        end
                        ptr_q         <= PTR_TOP;
                        lines_cleared <= 3'd0;
                        state_q       <= StScan;
                    end
                end
                StScan: begin
                    if (row_full) begin
                        state_q <= StShift;
                    end else if (ptr_q == '0) begin
                        state_q     <= StDone;
                        lines_valid <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q - PTR_W'(1);
                    end
                end
                StShift: begin
                    // Pointer stays put so the row that just moved down gets re-tested.
                    grid <= shifted;
                    if (lines_cleared != 3'd7) begin
                        lines_cleared <= lines_cleared + 3'd1;
                    end
                    state_q <= StScan;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_manager.sv
// Self-checking bench for grid_manager: scoreboard of expected lock outcomes plus directed aborts.
module tb_grid_manager;

    import grid_manager_pkg::*;

    typedef logic [CELLS-1:0] val_t;

    typedef struct {
        val_t       grid;
        logic [2:0] lines;
        logic       go;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock_valid = 1'b0;
    val_t       lock_mask = '0;
    logic       clear_all = 1'b0;
    logic       lock_ready;
    val_t       grid;
    logic       busy;
    logic       lines_valid;
    logic [2:0] lines_cleared;
    logic       game_over;

    int   n_checks = 0;
    int   n_pass   = 0;
    val_t model_grid = '0;
    logic model_go   = 1'b0;
    exp_t sb[$];

    grid_manager #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lock_valid    (lock_valid),
        .lock_mask     (lock_mask),
        .lock_ready    (lock_ready),
        .clear_all     (clear_all),
        .grid          (grid),
        .busy          (busy),
        .lines_valid   (lines_valid),
        .lines_cleared (lines_cleared),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input val_t obs, input val_t want);
        n_checks++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, want);
    endtask

    function automatic val_t row_bits(input int r, input logic [COLS-1:0] bits);
        val_t v;
        v = '0;
        v[r*COLS +: COLS] = bits;
        return v;
    endfunction

    // Reference: keep the non-full rows in order, packed against the bottom.
    function automatic void settle(input val_t g, output val_t res, output int n);
        int w;
        w   = ROWS - 1;
        res = '0;
        n   = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (&g[r*COLS +: COLS]) begin
                n++;
            end else begin
                res[w*COLS +: COLS] = g[r*COLS +: COLS];
                w--;
            end
        end
    endfunction

    task automatic lock_piece(input val_t m);
        exp_t e;
        int   n;
        int   cyc;
        int   waitc;
        e.go = model_go | (|(model_grid & m));
        settle(model_grid | m, e.grid, n);
        e.lines = (n > 7) ? 3'd7 : 3'(n);
        e.lat   = ROWS + 1 + 2 * n;
        sb.push_back(e);

        @(negedge clk);
        lock_valid = 1'b1;
        lock_mask  = m;
        waitc = 0;
        while (!lock_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check("ready_before_lock", val_t'(lock_ready), val_t'(1));
        @(negedge clk);
        lock_valid = 1'b0;
        cyc = 1;
        while (!lines_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        check("latency", val_t'(cyc), val_t'(e.lat));
        check("grid", grid, e.grid);
        check("lines_cleared", val_t'(lines_cleared), val_t'(e.lines));
        check("game_over", val_t'(game_over), val_t'(e.go));
        check("busy_in_done", val_t'(busy), val_t'(1));
        @(negedge clk);
        check("pulse_width", val_t'(lines_valid), val_t'(0));
        check("ready_after", val_t'(lock_ready), val_t'(1));
        check("lines_held", val_t'(lines_cleared), val_t'(e.lines));
        model_grid = e.grid;
        model_go   = e.go;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all  = 1'b0;
        model_grid = '0;
        model_go   = 1'b0;
        check("clear_grid", grid, val_t'(0));
        check("clear_game_over", val_t'(game_over), val_t'(0));
        check("clear_lines", val_t'(lines_cleared), val_t'(0));
        check("clear_busy", val_t'(busy), val_t'(0));
    endtask

    task automatic watch_no_pulse(input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (lines_valid) seen++;
        end
        check("no_pulse", val_t'(seen), val_t'(0));
    endtask

    initial begin
        // Reset values while rst is held.
        #1;
        check("rst_grid", grid, val_t'(0));
        check("rst_busy", val_t'(busy), val_t'(0));
        check("rst_lines_valid", val_t'(lines_valid), val_t'(0));
        check("rst_lines", val_t'(lines_cleared), val_t'(0));
        check("rst_game_over", val_t'(game_over), val_t'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", val_t'(lock_ready), val_t'(1));

        // Plain lock, no full rows.
        lock_piece(row_bits(29, 10'h00F));
        do_clear();

        // Single row completed by the second lock.
        lock_piece(row_bits(29, 10'h03F));
        lock_piece(row_bits(29, 10'h3C0));

        // Tetris: vertical I-piece in column 0 completes rows 26..29.
        lock_piece(row_bits(26, 10'h3FE) | row_bits(27, 10'h3FE) |
                   row_bits(28, 10'h3FE) | row_bits(29, 10'h3FE));
        lock_piece(row_bits(26, 10'h001) | row_bits(27, 10'h001) |
                   row_bits(28, 10'h001) | row_bits(29, 10'h001));

        // Two clears drop the 0x155 pattern from row 27 to row 29.
        lock_piece(row_bits(27, 10'h155) | row_bits(28, 10'h1FF) | row_bits(29, 10'h1FF));
        lock_piece(row_bits(28, 10'h200) | row_bits(29, 10'h200));
        check("pattern_row29", val_t'(grid[29*COLS +: COLS]), val_t'(10'h155));

        // Collision sets sticky game_over; a clean lock afterwards keeps it.
        lock_piece(row_bits(29, 10'h001) | row_bits(28, 10'h001));
        lock_piece(row_bits(0, 10'h3F0));
        check("go_sticky", val_t'(game_over), val_t'(1));
        do_clear();

        // Eight rows at once: count saturates at 7.
        lock_piece(row_bits(22, '1) | row_bits(23, '1) | row_bits(24, '1) | row_bits(25, '1) |
                   row_bits(26, '1) | row_bits(27, '1) | row_bits(28, '1) | row_bits(29, '1));

        // clear_all in cycle 10 of the scan aborts without a pulse.
        @(negedge clk);
        lock_valid = 1'b1;
        lock_mask  = row_bits(29, 10'h00F);
        @(negedge clk);
        lock_valid = 1'b0;
        check("abort_busy", val_t'(busy), val_t'(1));
        repeat (9) @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        check("abort_grid", grid, val_t'(0));
        check("abort_idle", val_t'(lock_ready), val_t'(1));
        watch_no_pulse(40);

        // clear_all beats a simultaneous lock.
        @(negedge clk);
        clear_all  = 1'b1;
        lock_valid = 1'b1;
        lock_mask  = row_bits(29, 10'h0F0);
        @(negedge clk);
        clear_all  = 1'b0;
        lock_valid = 1'b0;
        check("clr_lock_grid", grid, val_t'(0));
        check("clr_lock_busy", val_t'(busy), val_t'(0));

        // rst in the SHIFT cycle of a sweep.
        lock_piece(row_bits(0, 10'h001));
        lock_piece(row_bits(0, 10'h001));
        lock_piece(row_bits(29, 10'h1FF));
        @(negedge clk);
        lock_valid = 1'b1;
        lock_mask  = row_bits(29, 10'h200);
        @(negedge clk);
        lock_valid = 1'b0;
        @(negedge clk);
        check("shift_busy", val_t'(busy), val_t'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_grid", grid, val_t'(0));
        check("mid_rst_busy", val_t'(busy), val_t'(0));
        check("mid_rst_valid", val_t'(lines_valid), val_t'(0));
        check("mid_rst_lines", val_t'(lines_cleared), val_t'(0));
        check("mid_rst_go", val_t'(game_over), val_t'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", val_t'(lock_ready), val_t'(1));
        watch_no_pulse(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/grid_manager.md
GRID_MANAGER -- requirements
Module: grid_manager

Interface
REQ-001 Parameters SHALL be: ROWS, default 30, playfield rows; COLS, default 10, playfield columns.
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit: asynchronous, active-high reset.
REQ-004 Port lock_valid SHALL be input, 1 bit: a settled piece is offered for merge.
REQ-005 Port lock_mask SHALL be input, ROWS*COLS bits: cells of the settled piece, same indexing as grid.
REQ-006 Port lock_ready SHALL be output, 1 bit: high only in IDLE, when the block can accept a lock.
REQ-007 Port clear_all SHALL be input, 1 bit: wipe the playfield (new game).
REQ-008 Port grid SHALL be output, ROWS*COLS bits: registered playfield; bit i is column i%COLS, row i/COLS; row 0 is the top row.
REQ-009 Port busy SHALL be output, 1 bit: high whenever state is not IDLE.
REQ-010 Port lines_valid SHALL be output, 1 bit: one-cycle pulse marking the end of a lock sequence.
REQ-011 Port lines_cleared SHALL be output, 3 bits: count of rows removed by the last lock; valid while lines_valid is high; held until the next lock.
REQ-012 Port game_over SHALL be output, 1 bit: sticky flag set on collision at merge.

Function
REQ-013 The block SHALL have four states, IDLE, SCAN, SHIFT and DONE, with one state per cycle.
REQ-014 On the edge where lock_valid and lock_ready are both high:
- grid SHALL become grid | lock_mask;
- the row pointer SHALL be set to ROWS-1;
- the line count SHALL be set to 0;
- the state SHALL become SCAN.
REQ-015 In SCAN, the row at the pointer SHALL be tested; a row is full when all COLS bits are 1.
- full row: next state SHALL be SHIFT;
- not full, pointer 0: next state SHALL be DONE;
- not full, pointer above 0: the pointer SHALL decrement and the state SHALL stay SCAN.
REQ-016 In SHIFT:
- rows 1 through pointer SHALL take the contents of rows 0 through pointer-1;
- row 0 SHALL become all zero;
- rows below the pointer SHALL be unchanged;
- the line count SHALL increment, saturating at 7;
- the state SHALL return to SCAN with the pointer unchanged, so the same row is re-tested.
REQ-017 In DONE, lines_valid SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-018 Latency with no full rows SHALL be as follows:
- lock accepted at edge E0;
- 30 SCAN cycles follow;
- lines_valid is high in cycle 31 after E0;
- lock_ready is high again in cycle 32.
REQ-019 Each cleared row SHALL add exactly 2 cycles to that latency.
REQ-020 If (grid & lock_mask) is nonzero at the accept edge, game_over SHALL be set; the merge SHALL still occur.
REQ-021 Only clear_all or rst SHALL clear game_over.
REQ-022 clear_all SHALL have priority over every other input in every state. On the next edge:
- grid SHALL be 0;
- game_over SHALL be 0;
- lines_cleared SHALL be 0;
- the state SHALL be IDLE;
- no lines_valid pulse SHALL be produced for an aborted sequence.
REQ-023 clear_all and lock_valid asserted together SHALL clear the playfield and SHALL NOT merge the lock.
REQ-024 lock_valid outside IDLE SHALL be ignored; the offering stage holds it until lock_ready.
REQ-025 Only a lock or clear_all SHALL change grid while in IDLE.

Reset
REQ-026 While rst is high, the block SHALL immediately hold:
- grid = 0, state = IDLE, row pointer = ROWS-1;
- lines_cleared = 0, lines_valid = 0, game_over = 0, busy = 0;
- lock_ready = 1 from the first cycle after rst is released.
REQ-027 rst asserted mid-sequence SHALL discard the sequence with no lines_valid pulse.

Structure
REQ-028 The following SHALL live in the shared tetris constants package:
- ROWS, COLS and CELLS (ROWS*COLS);
- the state encoding;
- the 16-pixel cell size used by the renderer.
REQ-029 One sub-module, grid_row_select, SHALL extract the COLS-bit row at a given pointer and output its full flag.
REQ-030 All other logic SHALL sit in grid_manager: FSM, pointer, counter and shift network.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Empty grid, lock_mask = bits 290..293 → grid = 0x0F in row 29; lines_valid in cycle 31 after accept; lines_cleared = 0; game_over = 0.
- Row 29 bits 290..295 preset, lock bits 296..299 → row 29 cleared, row 29 = 0; lines_valid in cycle 33; lines_cleared = 1.
- Rows 26–29 full except column 0, vertical I-piece in column 0 → all four rows cleared; lines_cleared = 4; lines_valid in cycle 39.
- Rows 28 and 29 full and row 27 = 0x155 pattern, with no lock-induced overlap → row 27 pattern moves to row 29 after the clears.
- Lock overlapping an occupied cell → game_over = 1 and merge performed; game_over stays 1 through the next lock until clear_all.
- clear_all asserted in cycle 10 of a SCAN → grid = 0 and IDLE next edge; no lines_valid; rst mid-SHIFT → all outputs at reset values immediately.
